prv332_selftest_soc: RTL and testbench
======================================

# prv332_selftest_soc

Self-test SoC top for the PRV332 platform. It replaces the CPU with a hardwired test sequencer that drives the SoC pinout on one clock. The sequencer exercises an external asynchronous 32-bit SRAM (word and byte-lane write/readback) and a GPIO loopback (AFGPIO[11] output wired to AFGPIO[12] input on the board), then reports pass/fail on dedicated GPIO pins. The SPI port is present for pin compatibility and is held idle.

## Interface
- DEPTH, 16: number of SRAM words tested, at addresses 0..DEPTH-1 (1..4096).
- PATTERN, 32'hA5A5_5A5A: word-test seed; data(a) = PATTERN ^ {10'b0, a[21:0]}.
- CLK  in  1  single system clock; all logic on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- AFGPIO  inout  23  [0]=PASS, [1]=FAIL, [2]=DONE, [10:3]=error count, [11]=loopback out, [12]=loopback in; [22:13] high-Z.
- SPI_CS  out  1  held 1.
- SPI_MOSI  out  1  held 0.
- SPI_MISO  in  1  ignored.
- SPI_SCLK  out  1  held 0.
- SRAM_Addr  out  22  word address.
- SRAM_Data  inout  32  driven only during write states, high-Z otherwise.
- SRAM_BSEL  out  4  byte enables, active-low; bit n enables Data[8n+7:8n].
- SRAM_CS  out  1  chip select, active-low.
- SRAM_WR  out  1  write strobe, active-low.
- SRAM_OE  out  1  output enable, active-low.
- SRAM_RDY  in  1  high = access may complete; sampled in STROBE and SAMPLE.

## Operation
- States, in order: IDLE → W_SETUP → W_STROBE → W_HOLD (repeat per word) → R_SETUP → R_SAMPLE (repeat per word) → B_SETUP → B_STROBE → B_HOLD → B_RSETUP → B_RSAMPLE → G_HI → G_LO → DONE.
- IDLE: lasts one cycle after reset release; address counter = 0.
- Word write:
  - W_SETUP: CS=0, Addr=a, Data=data(a), BSEL=4'b0000, WR=1.
  - W_STROBE: WR=0. Stays in W_STROBE while RDY=0.
  - W_HOLD: WR=1, data still driven. Then a+1, or R_SETUP with a=0 after DEPTH-1.
- Word read:
  - R_SETUP: CS=0, OE=0, BSEL=0, Data high-Z.
  - R_SAMPLE: waits for RDY=1, then captures SRAM_Data and compares with data(a).
- Byte-lane test, address 0:
  - Write: B_* states write Data[15:8]=8'h3C with BSEL=4'b1101.
  - Readback: expects {data(0)[31:16], 8'h3C, data(0)[7:0]}.
- G_HI: drives AFGPIO[11]=1 for 3 cycles, then samples AFGPIO[12] through a 2-flop synchronizer; expects 1.
- G_LO: the same with 0; expects 0.
- Each failed compare increments an 8-bit error count, saturating at 255.
- DONE:
  - Outputs: DONE=1; PASS=(count==0), FAIL=(count!=0).
  - Holds until reset; SRAM bus idle.
- Idle SRAM bus (all states outside the word/byte tests): CS=WR=OE=1, BSEL=4'hF, Addr=0, Data high-Z.

## Timing
- Reset values:
  - SRAM bus: idle.
  - SPI: SPI_CS=1, SCLK=0, MOSI=0.
  - AFGPIO: [2:0]=0, [10:3]=0, [11]=0; all other pins high-Z.
- Reset clears the error count, the state and the counter.
- Reset mid-operation: on the first rising edge with RST=1, all outputs return to reset values and Data is released. There is no completion of a pending write.
- Per-access latency with RDY=1: write 3 cycles; read 2 cycles, with data captured at the end of R_SAMPLE.
- Each cycle with RDY=0 adds one cycle to STROBE or SAMPLE.
- No timeout on RDY.
- WR and OE are never both 0 in the same cycle.
- Data is never driven while OE=0.
- Total runtime with DEPTH=16 and RDY=1:
  - 1 (IDLE) + 48 (writes) + 32 (reads) + 5 (byte test) + 10 (GPIO: two 5-cycle phases of 3 drive + 2 sync) = 96 cycles.
  - DONE is asserted on cycle 97 after reset release.
- Address counter width is 22 bits; DEPTH never wraps it.

## Test plan
- Behavioral async SRAM, RDY=1, loopback present, DEPTH=16 → DONE=1, PASS=1, FAIL=0, count=0 at cycle 97; SRAM word 5 = 32'hA5A5_5A5F; word 0 = 32'hA5A5_3C5A.
- Same, with the SRAM model forcing bit 0 of address 3 stuck at 0 → FAIL=1, PASS=0, count=1.
- Loopback removed (AFGPIO[12] pulled 0) → FAIL=1, count=1; SRAM checks pass.
- RDY held low 4 cycles during the first W_STROBE:
  - WR stays 0 throughout, no address advance.
  - DONE is asserted 4 cycles later than nominal (cycle 101).
- RST asserted during R_SAMPLE of word 7 → next edge: CS=OE=1, Data high-Z, GPIO[2:0]=0. After release the full sequence reruns and passes.
- Every cycle: never WR=0 and OE=0 together; SPI_CS=1 and SCLK=0 throughout; AFGPIO[22:13] high-Z.

Source files
------------

// File: rtl/prv332_selftest_soc.sv
// PRV332 self-test SoC top: a hardwired sequencer that exercises the async SRAM
// (word and byte-lane write/readback) and the AFGPIO[11]->[12] board loopback.
module prv332_selftest_soc #(
    parameter int unsigned DEPTH   = 16,
    parameter logic [31:0] PATTERN = 32'hA5A5_5A5A
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [22:0] AFGPIO,
    output logic        SPI_CS,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    output logic        SPI_SCLK,
    output logic [21:0] SRAM_Addr,
    inout  wire  [31:0] SRAM_Data,
    output logic [3:0]  SRAM_BSEL,
    output logic        SRAM_CS,
    output logic        SRAM_WR,
    output logic        SRAM_OE,
    input  logic        SRAM_RDY
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_STROBE,
        S_W_HOLD,
        S_R_SETUP,
        S_R_SAMPLE,
        S_B_SETUP,
        S_B_STROBE,
        S_B_HOLD,
        S_B_RSETUP,
        S_B_RSAMPLE,
        S_G_HI,
        S_G_LO,
        S_DONE
    } state_e;

    localparam logic [21:0] LAST_ADDR = 22'(DEPTH - 1);
    localparam logic [2:0]  GPIO_LAST = 3'd4;   // 3 drive cycles + 2 synchronizer cycles
    // Byte-lane test only rewrites Data[15:8] of word 0.
    localparam logic [31:0] BYTE_WORD = {PATTERN[31:16], 8'h3C, PATTERN[7:0]};

    function automatic logic [31:0] word_data(input logic [21:0] a);
        return PATTERN ^ {10'b0, a};
    endfunction

    state_e      state_q, state_d;
    logic [21:0] addr_q, addr_d;
    logic [2:0]  phase_q, phase_d;
    logic [7:0]  err_q, err_d;
    logic [1:0]  sync_q;

    logic        err_inc;
    logic        cs_n, wr_n, oe_n;
    logic [3:0]  bsel_n;
    logic [21:0] addr_o;
    logic        data_drv;
    logic [31:0] wdata;
    logic        loop_out;
    logic        done;

    // NOTE: every output of this block is given a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        phase_d  = phase_q;
        err_inc  = 1'b0;
        cs_n     = 1'b1;
        wr_n     = 1'b1;
        oe_n     = 1'b1;
        bsel_n   = 4'hF;
        addr_o   = '0;
        data_drv = 1'b0;
        wdata    = '0;
        loop_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                addr_d  = '0;
                state_d = S_W_SETUP;
            end
            S_W_SETUP, S_W_STROBE, S_W_HOLD: begin
                cs_n     = 1'b0;
                bsel_n   = 4'b0000;
                addr_o   = addr_q;
                data_drv = 1'b1;
                wdata    = word_data(addr_q);
                if (state_q == S_W_SETUP) begin
                    state_d = S_W_STROBE;
                end else if (state_q == S_W_STROBE) begin
                    wr_n = 1'b0;
                    if (SRAM_RDY) state_d = S_W_HOLD;
                end else if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_R_SETUP;
                end else begin
                    addr_d  = addr_q + 22'd1;
                    state_d = S_W_SETUP;
                end
            end
            S_R_SETUP, S_R_SAMPLE: begin
                cs_n   = 1'b0;
                oe_n   = 1'b0;
                bsel_n = 4'b0000;
                addr_o = addr_q;
                if (state_q == S_R_SETUP) begin
                    state_d = S_R_SAMPLE;
                end else if (SRAM_RDY) begin
                    err_inc = (SRAM_Data != word_data(addr_q));
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = S_B_SETUP;
                    end else begin
                        addr_d  = addr_q + 22'd1;
                        state_d = S_R_SETUP;
                    end
                end
            end
            S_B_SETUP, S_B_STROBE, S_B_HOLD: begin
                cs_n     = 1'b0;
                bsel_n   = 4'b1101;
                data_drv = 1'b1;
                wdata    = BYTE_WORD;
                if (state_q == S_B_SETUP) begin
                    state_d = S_B_STROBE;
                end else if (state_q == S_B_STROBE) begin
                    wr_n = 1'b0;
                    if (SRAM_RDY) state_d = S_B_HOLD;
                end else begin
                    state_d = S_B_RSETUP;
                end
            end
            S_B_RSETUP, S_B_RSAMPLE: begin
                cs_n   = 1'b0;
                oe_n   = 1'b0;
                bsel_n = 4'b0000;
                if (state_q == S_B_RSETUP) begin
                    state_d = S_B_RSAMPLE;
                end else if (SRAM_RDY) begin
                    err_inc = (SRAM_Data != BYTE_WORD);
                    phase_d = '0;
                    state_d = S_G_HI;
                end
            end
            S_G_HI: begin
                loop_out = 1'b1;
                if (phase_q == GPIO_LAST) begin
                    err_inc = !sync_q[1];
                    phase_d = '0;
                    state_d = S_G_LO;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            S_G_LO: begin
                if (phase_q == GPIO_LAST) begin
                    err_inc = sync_q[1];
                    phase_d = '0;
                    state_d = S_DONE;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            phase_q <= '0;
            err_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            sync_q  <= {sync_q[0], AFGPIO[12]};
        end
    end

    assign done = (state_q == S_DONE);

    assign SRAM_CS   = cs_n;
    assign SRAM_WR   = wr_n;
    assign SRAM_OE   = oe_n;
    assign SRAM_BSEL = bsel_n;
    assign SRAM_Addr = addr_o;
    assign SRAM_Data = data_drv ? wdata : 'z;

    assign SPI_CS   = 1'b1;
    assign SPI_MOSI = 1'b0;
    assign SPI_SCLK = 1'b0;

    assign AFGPIO[0]     = done && (err_q == 8'd0);
    assign AFGPIO[1]     = done && (err_q != 8'd0);
    assign AFGPIO[2]     = done;
    assign AFGPIO[10:3]  = err_q;
    assign AFGPIO[11]    = loop_out;
    assign AFGPIO[22:12] = 'z;

    logic unused_ok;
    assign unused_ok = ^{SPI_MISO, AFGPIO[22:13], AFGPIO[11:0]};

endmodule

// File: tb/tb_prv332_selftest_soc.sv
// Directed bench for prv332_selftest_soc: behavioral async SRAM, switchable GPIO
// loopback, stuck-bit injection, RDY stall and mid-run reset.
module tb_prv332_selftest_soc;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic rdy      = 1'b1;
    logic loop_en  = 1'b1;
    logic stuck_en = 1'b0;
    logic mon_en   = 1'b0;

    wire  [22:0] gpio;
    wire  [31:0] sram_data;
    logic        spi_cs, spi_mosi, spi_sclk;
    logic [21:0] sram_addr;
    logic [3:0]  sram_bsel;
    logic        sram_cs, sram_wr, sram_oe;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];
    logic [31:0] rd_word;

    always #5 clk = ~clk;

    prv332_selftest_soc #(
        .DEPTH   (16),
        .PATTERN (32'hA5A5_5A5A)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .AFGPIO    (gpio),
        .SPI_CS    (spi_cs),
        .SPI_MOSI  (spi_mosi),
        .SPI_MISO  (1'b0),
        .SPI_SCLK  (spi_sclk),
        .SRAM_Addr (sram_addr),
        .SRAM_Data (sram_data),
        .SRAM_BSEL (sram_bsel),
        .SRAM_CS   (sram_cs),
        .SRAM_WR   (sram_wr),
        .SRAM_OE   (sram_oe),
        .SRAM_RDY  (rdy)
    );

    // Board loopback; when removed the input pin is pulled low.
    assign gpio[12] = loop_en ? gpio[11] : 1'b0;

    always_comb begin
        rd_word = mem[sram_addr[5:0]];
        if (stuck_en && sram_addr == 22'd3) rd_word[0] = 1'b0;
    end
    assign sram_data = (!sram_cs && !sram_oe) ? rd_word : 32'bz;

    always @(posedge clk) begin
        if (!sram_cs && !sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_bsel[b]) mem[sram_addr[5:0]][8*b +: 8] <= sram_data[8*b +: 8];
            end
        end
    end

    // Bus and SPI invariants, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert (!(sram_wr === 1'b0 && sram_oe === 1'b0) && spi_cs === 1'b1
                    && spi_sclk === 1'b0 && spi_mosi === 1'b0)
            else begin
                errors++;
                $error("FAIL bus_invariant wr=%b oe=%b spi_cs=%b sclk=%b mosi=%b expected no wr&oe, cs=1 sclk=0 mosi=0",
                       sram_wr, sram_oe, spi_cs, spi_sclk, spi_mosi);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Counts rising edges since release until DONE is seen (bounded).
    task automatic run_to_done(input int start, output int edges);
        edges = start;
        while (edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            if (gpio[2] === 1'b1) break;
        end
    endtask

    task automatic check_result(input string tag, input int edges, input int exp_edges,
                                input logic pass, input logic [7:0] cnt);
        check({tag, "_done_edge"}, 32'(edges), 32'(exp_edges));
        check({tag, "_pass"}, {31'b0, gpio[0]}, {31'b0, pass});
        check({tag, "_fail"}, {31'b0, gpio[1]}, {31'b0, !pass});
        check({tag, "_count"}, {24'b0, gpio[10:3]}, {24'b0, cnt});
    endtask

    int edges;

    initial begin
        // Reset state
        hold_reset();
        check("rst_cs",    {31'b0, sram_cs}, 32'd1);
        check("rst_wr",    {31'b0, sram_wr}, 32'd1);
        check("rst_oe",    {31'b0, sram_oe}, 32'd1);
        check("rst_bsel",  {28'b0, sram_bsel}, 32'hF);
        check("rst_addr",  {10'b0, sram_addr}, 32'd0);
        check("rst_gpio",  {21'b0, gpio[10:0]}, 32'd0);
        mon_en = 1'b1;

        // Nominal run: DONE appears after the 96th edge (cycle 97).
        rst = 1'b0;
        run_to_done(0, edges);
        check_result("nominal", edges, 96, 1'b1, 8'd0);
        check("nominal_word5", mem[5], 32'hA5A5_5A5F);
        check("nominal_word0", mem[0], 32'hA5A5_3C5A);
        check("nominal_word15", mem[15], 32'hA5A5_5A55);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", {29'b0, gpio[2:0]}, 32'b101);
        check("done_bus_idle", {31'b0, sram_cs}, 32'd1);

        // Stuck bit 0 on read of word 3
        stuck_en = 1'b1;
        hold_reset();
        check("rerst_gpio", {21'b0, gpio[10:0]}, 32'd0);
        rst = 1'b0;
        run_to_done(0, edges);
        check_result("stuck", edges, 96, 1'b0, 8'd1);
        stuck_en = 1'b0;

        // Loopback removed
        loop_en = 1'b0;
        hold_reset();
        rst = 1'b0;
        run_to_done(0, edges);
        check_result("noloop", edges, 96, 1'b0, 8'd1);
        loop_en = 1'b1;

        // RDY low for 4 cycles in the first W_STROBE
        hold_reset();
        rdy = 1'b0;
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                check("stall_wr", {31'b0, sram_wr}, 32'd0);
                check("stall_addr", {10'b0, sram_addr}, 32'd0);
            end
        end
        rdy = 1'b1;
        run_to_done(6, edges);
        check_result("stall", edges, 100, 1'b1, 8'd0);

        // Reset during R_SAMPLE of word 7 (after edge 64)
        hold_reset();
        rst = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        check("mid_oe", {31'b0, sram_oe}, 32'd0);
        check("mid_addr", {10'b0, sram_addr}, 32'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_cs", {31'b0, sram_cs}, 32'd1);
        check("mid_rst_oe", {31'b0, sram_oe}, 32'd1);
        check("mid_rst_wr", {31'b0, sram_wr}, 32'd1);
        check("mid_rst_gpio", {29'b0, gpio[2:0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_to_done(0, edges);
        check_result("rerun", edges, 96, 1'b1, 8'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
